// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - state encoding and counter sizing for the clock divide detector
// Contents:
//   det_state_t : detector FSM states (IDLE, ARM, MEASURE, LOCKED)
//   cnt_width() : period counter width for a given divide-code width

package clock_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } det_state_t;

  // The longest legal period is 2^(2^div_width); one extra bit lets the
  // counter sit at that value so the timeout is seen before any wrap.
  function automatic int cnt_width(input int div_width);
    return (1 << div_width) + 1;
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - two-flop synchronizer with rising-edge detect
// Ports:
//   clk_in   : sampling clock
//   rst      : synchronous, active-high reset
//   async_in : asynchronous input to be synchronized
//   level    : synchronized level
//   rise     : one-cycle pulse on a synchronized rising edge

module clk_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~sync_q;

endmodule

// File: rtl/clock_div_detector.sv
// rtl/clock_div_detector.sv - recovers the divide-stage code of an observed divided clock
// Ports:
//   clk_in     : system clock, also the divider source
//   rst        : synchronous, active-high reset
//   div_clk    : divided clock under observation
//   meas_en    : measurement enable, low forces IDLE
//   div_code   : recovered divide-stage code (period = 2^(code+1) clk_in cycles)
//   code_valid : one-cycle pulse per accepted period
//   locked     : level, LOCK_COUNT consecutive identical codes seen
//   err        : one-cycle pulse on bad period, code change while locked, or timeout
//   duty_err   : one-cycle pulse with code_valid when the high phase is not half the period
// Build option: CLK_DIV_DET_DUTY_CHECK_EN enables the duty-cycle check; otherwise duty_err is 0.

module clock_div_detector
  import clock_div_pkg::*;
#(
  parameter int DIV_WIDTH  = 3,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 div_clk,
  input  logic                 meas_en,
  output logic [DIV_WIDTH-1:0] div_code,
  output logic                 code_valid,
  output logic                 locked,
  output logic                 err,
  output logic                 duty_err
);

  localparam int              CW       = cnt_width(DIV_WIDTH);
  localparam int              MW       = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]   MAX_P    = CW'(1) << (1 << DIV_WIDTH);
  localparam logic [MW-1:0]   LOCK_VAL = MW'(LOCK_COUNT);

  det_state_t           state;
  det_state_t           state_d;
  logic                 rise;
  logic                 sync_lvl;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        period;
  logic [MW-1:0]        mcnt;
  logic [MW-1:0]        mcnt_inc;
  logic [DIV_WIDTH-1:0] meas_code;
  logic                 in_meas;
  logic                 p_ok;
  logic                 same_code;
  logic                 ev_accept;
  logic                 ev_reject;
  logic                 ev_timeout;
  logic                 code_change;

  clk_edge_sync u_edge (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (div_clk),
    .level    (sync_lvl),
    .rise     (rise)
  );

  assign period  = cnt + CW'(1);
  assign in_meas = meas_en && (state == ST_MEASURE || state == ST_LOCKED);

  // Legal periods are single-bit values from 2 up to MAX_P.
  assign p_ok = (period >= CW'(2)) && (period <= MAX_P) &&
                ((period & (period - CW'(1))) == '0);

  assign ev_accept  = in_meas && rise && p_ok;
  assign ev_reject  = in_meas && rise && !p_ok;
  assign ev_timeout = in_meas && !rise && (cnt == MAX_P);

  // A zero match count means no code has been accepted since the last
  // clear, so div_code is not a valid reference for comparison.
  assign same_code   = (mcnt != '0) && (meas_code == div_code);
  assign mcnt_inc    = !same_code ? MW'(1) :
                       (mcnt == LOCK_VAL) ? mcnt : mcnt + MW'(1);
  assign code_change = ev_accept && (state == ST_LOCKED) && !same_code;

  // log2(period) - 1; only meaningful when p_ok.
  always_comb begin
    meas_code = '0;
    for (int i = 1; i < CW; i++) begin
      if (period[i]) meas_code = DIV_WIDTH'(i - 1);
    end
  end

  always_comb begin
    state_d = state;
    if (!meas_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_d = ST_ARM;
        ST_ARM:     if (rise) state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (ev_timeout)                                state_d = ST_ARM;
          else if (ev_accept && mcnt_inc == LOCK_VAL)    state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (ev_timeout)                                state_d = ST_ARM;
          else if (ev_reject || code_change)             state_d = ST_MEASURE;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mcnt       <= '0;
      div_code   <= '0;
      code_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_d;

      // The timeout clears the counter, so it never advances past MAX_P.
      if (!in_meas || rise || ev_timeout) cnt <= '0;
      else                                cnt <= cnt + CW'(1);

      if (ev_accept)                               mcnt <= mcnt_inc;
      else if (!in_meas || ev_reject || ev_timeout) mcnt <= '0;

      code_valid <= ev_accept;
      if (ev_accept) div_code <= meas_code;
      err <= ev_reject || ev_timeout || code_change;
    end
  end

  always_comb begin
    locked = (state == ST_LOCKED);
  end

`ifdef CLK_DIV_DET_DUTY_CHECK_EN
  logic [CW-1:0] hcnt;
  logic [CW-1:0] hi_period;

  // The edge cycle itself is high and closes the period, hence the +1.
  assign hi_period = hcnt + CW'(1);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcnt     <= '0;
      duty_err <= 1'b0;
    end else begin
      if (rise || !in_meas) hcnt <= '0;
      else                  hcnt <= hcnt + CW'(sync_lvl);
      duty_err <= ev_accept && ({hi_period, 1'b0} != {1'b0, period});
    end
  end
`else
  logic unused_sync_lvl;
  assign unused_sync_lvl = sync_lvl;
  assign duty_err        = 1'b0;
`endif

endmodule

// File: tb/tb_clock_div_detector.sv
// tb/tb_clock_div_detector.sv - directed scoreboard bench for clock_div_detector

module tb_clock_div_detector;

  localparam int DW = 3;
  localparam int LC = 4;
  localparam int MAXP = 256;
`ifdef CLK_DIV_DET_DUTY_CHECK_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst;
  logic          div_clk;
  logic          meas_en;
  logic [DW-1:0] div_code;
  logic          code_valid;
  logic          locked;
  logic          err;
  logic          duty_err;

  always #5 clk_in = ~clk_in;

  clock_div_detector #(.DIV_WIDTH(DW), .LOCK_COUNT(LC)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div_clk    (div_clk),
    .meas_en    (meas_en),
    .div_code   (div_code),
    .code_valid (code_valid),
    .locked     (locked),
    .err        (err),
    .duty_err   (duty_err)
  );

  typedef struct packed {
    logic          cv;
    logic          er;
    logic [DW-1:0] code;
    logic          lk;
    logic          du;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Period-level reference model
  bit   armed;
  int   mcnt;
  int   last_code;
  bit   lockd;
  int   gap;
  int   hi;
  logic prev_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit p_legal(input int p);
    return (p >= 2) && (p <= MAXP) && ((p & (p - 1)) == 0);
  endfunction

  function automatic int log2i(input int p);
    int r = 0;
    while ((1 << (r + 1)) <= p) r++;
    return r;
  endfunction

  task automatic model_reset();
    armed = 1'b0; mcnt = 0; lockd = 1'b0; last_code = 0;
  endtask

  task automatic model_edge(input int p, input int h);
    exp_t e;
    int   code;
    bit   same;
    if (!armed) begin
      armed = 1'b1;
      return;
    end
    if (p_legal(p)) begin
      code = log2i(p) - 1;
      same = (mcnt > 0) && (code == last_code);
      e.er = lockd && !same;
      if (!same) begin
        mcnt  = 1;
        lockd = 1'b0;
      end else if (mcnt < LC) begin
        mcnt++;
      end
      if (mcnt == LC && !e.er) lockd = 1'b1;
      last_code = code;
      e.cv   = 1'b1;
      e.code = DW'(code);
      e.lk   = lockd;
      e.du   = DUTY_ON && (2 * h != p);
    end else begin
      mcnt   = 0;
      lockd  = 1'b0;
      e.cv   = 1'b0;
      e.er   = 1'b1;
      e.code = DW'(last_code);
      e.lk   = 1'b0;
      e.du   = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_timeout();
    exp_t e;
    e.cv = 1'b0; e.er = 1'b1; e.code = DW'(last_code); e.lk = 1'b0; e.du = 1'b0;
    exp_q.push_back(e);
    armed = 1'b0; mcnt = 0; lockd = 1'b0;
  endtask

  // One clk_in cycle of div_clk stimulus, driven on the falling edge.
  task automatic tick(input logic v);
    @(negedge clk_in);
    div_clk = v;
    gap++;
    if (v && !prev_v) begin
      model_edge(gap, hi);
      gap = 0;
      hi  = 1;
    end else begin
      hi += int'(v);
      if (armed && gap == MAXP + 1) model_timeout();
    end
    prev_v = v;
  endtask

  task automatic run(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) tick(i < h);
  endtask

  always @(negedge clk_in) begin
    if (code_valid || err || duty_err) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event got cv=%0b err=%0b duty=%0b exp none", code_valid, err, duty_err);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("ev_code_valid", 32'(code_valid), 32'(mon_e.cv));
        chk("ev_err",        32'(err),        32'(mon_e.er));
        chk("ev_div_code",   32'(div_code),   32'(mon_e.code));
        chk("ev_locked",     32'(locked),     32'(mon_e.lk));
        chk("ev_duty_err",   32'(duty_err),   32'(mon_e.du));
      end
    end
  end

  initial begin
    rst = 1'b1; div_clk = 1'b0; meas_en = 1'b0; prev_v = 1'b0;
    gap = 0; hi = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    chk("rst_code_valid", 32'(code_valid), 32'd0);
    chk("rst_err",        32'(err),        32'd0);
    chk("rst_locked",     32'(locked),     32'd0);
    chk("rst_div_code",   32'(div_code),   32'd0);
    chk("rst_duty_err",   32'(duty_err),   32'd0);
    rst = 1'b0;
    meas_en = 1'b1;
    repeat (4) tick(1'b0);

    // Period 8, 50% duty: code 2, lock on 4th code_valid
    run(8, 4, 6);
    chk("lock_p8", 32'(locked), 32'd1);
    chk("drain_p8", 32'(exp_q.size()), 32'd0);

    // Switch to period 32: one err, relock on code 4
    run(32, 16, 6);
    chk("lock_p32", 32'(locked), 32'd1);
    chk("code_p32", 32'(div_code), 32'd4);

    // Period 6 rejected, then period 2 accepted as code 0
    run(6, 3, 2);
    chk("unlock_p6", 32'(locked), 32'd0);
    run(2, 1, 3);
    chk("code_p2", 32'(div_code), 32'd0);
    chk("nolock_p2", 32'(locked), 32'd0);

    // div_clk held low: timeout after 256 counts, back to ARM
    repeat (300) tick(1'b0);
    chk("timeout_locked", 32'(locked), 32'd0);
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    run(8, 4, 6);
    chk("relock_after_timeout", 32'(locked), 32'd1);

    // Reset for one cycle while locked, during the low phase
    repeat (4) tick(1'b1);
    repeat (2) tick(1'b0);
    chk("locked_before_rst", 32'(locked), 32'd1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    model_reset();
    chk("post_rst_locked",     32'(locked),     32'd0);
    chk("post_rst_div_code",   32'(div_code),   32'd0);
    chk("post_rst_code_valid", 32'(code_valid), 32'd0);
    chk("post_rst_err",        32'(err),        32'd0);
    chk("post_rst_duty_err",   32'(duty_err),   32'd0);
    tick(1'b0);
    run(8, 4, 4);
    chk("relock_not_yet", 32'(locked), 32'd0);
    run(8, 4, 2);
    chk("relock_after_rst", 32'(locked), 32'd1);

    // Period 8 with 3 high cycles: duty_err only when the check is built in
    run(8, 3, 3);
    chk("lock_duty", 32'(locked), 32'd1);

    // Disable measurement
    meas_en = 1'b0;
    repeat (3) tick(1'b0);
    chk("meas_en_off_locked", 32'(locked), 32'd0);
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
